icache_refill_ctrl: RTL

Miss-handling controller for the fetch stage's instruction cache. On an icache miss it stalls fetch and issues one block-aligned read burst on the AXI read channel. It assembles the returned beats into a full cache block and performs a single-cycle block write into the icache, then releases the stall. It sits between the fetch stage (hit, PC, write-enable/block, stall) and the instruction-side AXI read master.

---
 rtl/icache_refill_pkg.sv | 31 +++
 rtl/refill_block_assembler.sv | 68 ++++++
 rtl/icache_refill_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
// Shared types and sizing helpers for the instruction-cache refill controller.
//   refill_state_t : controller phase (IDLE, REQ, FILL, WRITE)
//   calc_beats     : AXI beats per cache block
//   calc_ofs       : byte-offset bits inside one cache block
//   calc_cnt_w     : width of the beat counter (at least 1 bit)
// -----------------------------------------------------------------------------
package icache_refill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  function automatic int unsigned calc_beats(int unsigned block_width,
                                             int unsigned data_width);
    return block_width / data_width;
  endfunction

  function automatic int unsigned calc_ofs(int unsigned block_width);
    return $clog2(block_width / 8);
  endfunction

  function automatic int unsigned calc_cnt_w(int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/refill_block_assembler.sv
// -----------------------------------------------------------------------------
// refill_block_assembler
// Beat counter plus block register. Each accepted beat lands in the slot
// selected by the counter; the counter wraps to zero after the final beat.
//   i_clk        clock
//   i_arst       asynchronous active-low reset
//   i_clear      restart the counter at slot 0 (new refill)
//   i_beat_valid accept i_beat_data into the current slot
//   i_beat_data  one AXI read beat
//   o_last_beat  counter sits on the final slot of the block
//   o_block      assembled block; changes only on accepted beats
// -----------------------------------------------------------------------------
module refill_block_assembler
  import icache_refill_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_clear,
  input  logic                   i_beat_valid,
  input  logic [DATA_WIDTH-1:0]  i_beat_data,
  output logic                   o_last_beat,
  output logic [BLOCK_WIDTH-1:0] o_block
);

  localparam int unsigned BEATS = calc_beats(BLOCK_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W = calc_cnt_w(BEATS);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] block_q, block_d;

  assign o_last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign o_block     = block_q;

  // NOTE: every always_comb output gets its default (hold) value first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    block_d = block_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_beat_valid) begin
      for (int b = 0; b < int'(BEATS); b++) begin
        if (cnt_q == CNT_W'(b)) begin
          block_d[b*DATA_WIDTH +: DATA_WIDTH] = i_beat_data;
        end
      end
      cnt_d = o_last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the block register is reset because its value is visible on
  // o_instr_block and must read as zero out of reset; it is flops, not a RAM.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Instruction-cache miss handler. On a miss it stalls fetch, issues one
// block-aligned AXI read burst, assembles the beats into a block, writes the
// block into the icache for one cycle, then releases the stall.
//
// Ports
//   i_clk, i_arst          clock, asynchronous active-low reset
//   i_icache_hit, i_pc     lookup result and current fetch PC
//   o_stall_fetch          hold PC register / branch predictor
//   o_instr_we, o_instr_block  one-cycle block write into the icache
//   o_ar_*, i_ar_ready     AXI read-address channel
//   i_r_*, o_r_ready       AXI read-data channel
//   o_refill_err           sticky RLAST-vs-beat-count mismatch flag
//   o_miss_count, o_stall_cycles  only when ICACHE_REFILL_PERF_EN is defined
//
// Configuration macro: ICACHE_REFILL_PERF_EN adds two free-running 32-bit
// performance counters; without it the ports and counters do not exist.
// -----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_refill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_icache_hit,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic                   o_stall_fetch,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_ar_valid,
  input  logic                   i_ar_ready,
  output logic [ADDR_WIDTH-1:0]  o_ar_addr,
  output logic [7:0]             o_ar_len,
  input  logic                   i_r_valid,
  input  logic [DATA_WIDTH-1:0]  i_r_data,
  input  logic                   i_r_last,
  output logic                   o_r_ready,
  output logic                   o_refill_err
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]            o_miss_count,
  output logic [31:0]            o_stall_cycles
`endif
);

  localparam int unsigned BEATS = calc_beats(BLOCK_WIDTH, DATA_WIDTH);
  localparam int unsigned OFS   = calc_ofs(BLOCK_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH - OFS){1'b1}}, {OFS{1'b0}}};

  refill_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   err_q, err_d;

  logic miss_start;
  logic beat_accept;
  logic last_beat;

  // A miss is only acted on from IDLE; once a refill is running it always
  // completes, since the fetched block is valid for its own address even if
  // fetch has been redirected meanwhile.
  assign miss_start  = (state_q == IDLE) && !i_icache_hit;
  assign beat_accept = (state_q == FILL) && i_r_valid;

  refill_block_assembler #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_assembler (
    .i_clk        (i_clk),
    .i_arst       (i_arst),
    .i_clear      (miss_start),
    .i_beat_valid (beat_accept),
    .i_beat_data  (i_r_data),
    .o_last_beat  (last_beat),
    .o_block      (o_instr_block)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!i_icache_hit) begin
          addr_d  = i_pc & ALIGN_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_ar_ready) state_d = FILL;
      end
      FILL: begin
        if (i_r_valid) begin
          // Completion follows the beat count; RLAST is only cross-checked.
          if (i_r_last != last_beat) err_d = 1'b1;
          if (last_beat) state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode straight from the state register, so they are
  // glitch-free and ARVALID cannot drop before ARREADY.
  assign o_ar_valid    = (state_q == REQ);
  assign o_r_ready     = (state_q == FILL);
  assign o_instr_we    = (state_q == WRITE);
  assign o_ar_addr     = addr_q;
  assign o_ar_len      = 8'(BEATS - 1);
  assign o_refill_err  = err_q;
  // The combinational miss term stalls fetch in the very cycle the miss is seen.
  assign o_stall_fetch = (state_q != IDLE) || !i_icache_hit;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] miss_count_q, stall_cycles_q;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      miss_count_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (miss_start)    miss_count_q   <= miss_count_q + 32'd1;
      if (o_stall_fetch) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign o_miss_count   = miss_count_q;
  assign o_stall_cycles = stall_cycles_q;
`endif

endmodule
